// File: rtl/seq_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types and constants for the sequential shift-and-add multiplier.
//   mult_state_t        : controller states (IDLE, CALC, DONE)
//   MULT_WIDTH_DEFAULT  : default operand width
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_WIDTH_DEFAULT = 8;

endpackage : mult_pkg

// File: rtl/seq_multiplier_if.sv
// -----------------------------------------------------------------------------
// seq_multiplier_if
// Request/response bundle between a controller (master) and the sequential
// multiplier (slave).
//   start_i  : request, sampled by the multiplier only while idle
//   A_i      : multiplicand          (WIDTH)
//   B_i      : multiplier            (WIDTH)
//   signed_i : two's-complement mode (only when MULT_SIGNED_EN is defined)
//   busy_o   : multiplier not idle
//   done_o   : one-cycle pulse, P_o valid
//   P_o      : product register      (2*WIDTH)
// Optional feature macro: MULT_SIGNED_EN
// -----------------------------------------------------------------------------
interface seq_multiplier_if #(
  parameter int WIDTH = mult_pkg::MULT_WIDTH_DEFAULT
);

  logic               start_i;
  logic [WIDTH-1:0]   A_i;
  logic [WIDTH-1:0]   B_i;
`ifdef MULT_SIGNED_EN
  logic               signed_i;
`endif
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] P_o;

`ifdef MULT_SIGNED_EN
  modport master (output start_i, A_i, B_i, signed_i,
                  input  busy_o, done_o, P_o);
  modport slave  (input  start_i, A_i, B_i, signed_i,
                  output busy_o, done_o, P_o);
`else
  modport master (output start_i, A_i, B_i,
                  input  busy_o, done_o, P_o);
  modport slave  (input  start_i, A_i, B_i,
                  output busy_o, done_o, P_o);
`endif

endinterface : seq_multiplier_if

// File: rtl/seq_multiplier_ripple_adder.sv
// -----------------------------------------------------------------------------
// ripple_adder
// N-bit ripple-carry adder built from a chain of full-adder cells.
//   a, b : addends (N)
//   cin  : carry into bit 0
//   sum  : result  (N)
//   cout : carry out of bit N-1
// -----------------------------------------------------------------------------
module ripple_adder #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule : ripple_adder

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Shift-and-add multiplier: one multiplier bit per clock, one (WIDTH+1)-bit
// ripple adder reused every cycle. Result after WIDTH+1 cycles, next request
// accepted WIDTH+2 cycles after the previous one.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : seq_multiplier_if.slave (start/operands in, busy/done/product out)
// Optional feature macro: MULT_SIGNED_EN adds per-operation two's-complement
// mode via bus.signed_i; without it the block is unsigned only.
// -----------------------------------------------------------------------------
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  seq_multiplier_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  mult_state_t        state;
  logic [WIDTH-1:0]   m;        // multiplicand
  logic [WIDTH-1:0]   q;        // multiplier, shifted out LSB first
  logic [WIDTH:0]     acc;      // upper partial product
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;

  logic               last_step;
  logic               sub;      // final-step subtract of the MSB weight
  logic [WIDTH:0]     ext_m;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic               cout;
  logic               ext_msb;
  logic [2*WIDTH:0]   shifted;  // {ACC,Q} after this step's add and shift

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULT_SIGNED_EN
  logic sgn;

  // In signed mode the multiplier's MSB carries negative weight, so the last
  // partial product is subtracted: ACC + ~ext(M) + 1.
  assign ext_m   = {sgn & m[WIDTH-1], m};
  assign sub     = sgn & last_step & q[0];
  assign ext_msb = sgn ? sum[WIDTH] : cout;
`else
  assign ext_m   = {1'b0, m};
  assign sub     = 1'b0;
  assign ext_msb = cout;
`endif

  assign addend  = q[0] ? (sub ? ~ext_m : ext_m) : '0;

  ripple_adder #(
    .N (WIDTH + 1)
  ) u_adder (
    .a    (acc),
    .b    (addend),
    .cin  (sub),
    .sum  (sum),
    .cout (cout)
  );

  assign shifted = {ext_msb, sum, q[WIDTH-1:1]};

  // NOTE: every register below is updated with non-blocking assignments so
  // all state advances together on the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      m     <= '0;
      q     <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
`ifdef MULT_SIGNED_EN
      sgn   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start_i) begin
            state <= CALC;
            busy  <= 1'b1;
            m     <= bus.A_i;
            q     <= bus.B_i;
            acc   <= '0;
            cnt   <= '0;
`ifdef MULT_SIGNED_EN
            sgn   <= bus.signed_i;
`endif
          end
        end

        CALC: begin
          acc <= shifted[2*WIDTH:WIDTH];
          q   <= shifted[WIDTH-1:0];
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            state <= DONE;
            done  <= 1'b1;
            p     <= shifted[2*WIDTH-1:0];
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o = busy;
  assign bus.done_o = done;
  assign bus.P_o    = p;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
// Directed-vector bench for seq_multiplier at WIDTH=8. Inputs are driven just
// after the falling edge, outputs are sampled on the falling edge.
// Signed vectors are included when MULT_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  int n_compared;
  int n_mismatched;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation: drive request, let the accepting edge pass, then watch
  // WIDTH+2 cycles. The call returns at the falling edge of the first idle
  // cycle, so the next call is accepted at the earliest legal edge.
  // hold     : keep start_i high throughout (back-to-back issue)
  // pulse_c  : if nonzero, pulse start_i with other operands in that cycle
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input bit hold, input int pulse_c,
                       input logic [2*W-1:0] exp_p);
    int busy_cnt;
    int done_cnt;
    int done_cyc;
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = 0;
    bus.A_i     = a;
    bus.B_i     = b;
`ifdef MULT_SIGNED_EN
    bus.signed_i = s;
`else
    if (s) $display("note: %s requests signed mode, unsupported in this build", tag);
`endif
    bus.start_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = c;
        check({tag, "/product"}, 64'(bus.P_o), 64'(exp_p));
      end
      if (c == W + 2) check({tag, "/p_hold"}, 64'(bus.P_o), 64'(exp_p));
      if (!hold) bus.start_i = 1'b0;
      if (pulse_c != 0 && c == pulse_c) begin
        bus.A_i     = 8'd99;
        bus.B_i     = 8'd99;
        bus.start_i = 1'b1;
      end
    end
    check({tag, "/latency"},   64'(done_cyc), 64'(W + 1));
    check({tag, "/done_cnt"},  64'(done_cnt), 64'd1);
    check({tag, "/busy_cyc"},  64'(busy_cnt), 64'(W + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    bus.start_i  = 1'b0;
    bus.A_i      = '0;
    bus.B_i      = '0;
`ifdef MULT_SIGNED_EN
    bus.signed_i = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset/busy", 64'(bus.busy_o), 64'd0);
    check("reset/done", 64'(bus.done_o), 64'd0);
    check("reset/p",    64'(bus.P_o),    64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle/busy",  64'(bus.busy_o), 64'd0);

    // Main vector: 200 x 150
    do_op("u200x150", 8'd200, 8'd150, 1'b0, 1'b0, 0, 16'd30000);

    // Unsigned corners, issued back-to-back with start held high
    do_op("u255x255", 8'd255, 8'd255, 1'b0, 1'b1, 0, 16'hFE01);
    do_op("u0x255",   8'd0,   8'd255, 1'b0, 1'b1, 0, 16'h0000);
    do_op("u1x1",     8'd1,   8'd1,   1'b0, 1'b1, 0, 16'h0001);

    // start pulsed during CALC with other operands: ignored
    do_op("pulse13x11", 8'd13, 8'd11, 1'b0, 1'b0, 3, 16'd143);
    repeat (3) @(negedge clk);
    check("pulse/no_extra_done", 64'(bus.done_o), 64'd0);
    check("pulse/no_extra_busy", 64'(bus.busy_o), 64'd0);
    check("pulse/p_kept",        64'(bus.P_o),    64'd143);

    // Reset asserted in cycle 4 of an operation
    bus.A_i     = 8'd200;
    bus.B_i     = 8'd150;
    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort/busy", 64'(bus.busy_o), 64'd0);
    check("abort/done", 64'(bus.done_o), 64'd0);
    check("abort/p",    64'(bus.P_o),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort/still_idle", 64'(bus.busy_o), 64'd0);
    check("abort/no_done",    64'(bus.done_o), 64'd0);
    do_op("u7x6", 8'd7, 8'd6, 1'b0, 1'b0, 0, 16'd42);

`ifdef MULT_SIGNED_EN
    do_op("s-3x5",       8'hFD, 8'h05, 1'b1, 1'b0, 0, 16'hFFF1);
    do_op("s-128x-128",  8'h80, 8'h80, 1'b1, 1'b0, 0, 16'h4000);
    do_op("s127x-128",   8'h7F, 8'h80, 1'b1, 1'b0, 0, 16'hC080);
    do_op("u128x128",    8'h80, 8'h80, 1'b0, 1'b0, 0, 16'h4000);
    do_op("s-1x1",       8'hFF, 8'h01, 1'b1, 1'b0, 0, 16'hFFFF);
    do_op("u255x1",      8'hFF, 8'h01, 1'b0, 1'b0, 0, 16'h00FF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_seq_multiplier
